// File: rtl/ram_arbiter2_pkg.sv
// Shared definitions for the two-port BRAM arbiter.
//   state_t  : access sequencer states (2'd3 is unused and decodes to IDLE)
//   PORT_A/B : port index values used for the winner and last-owner flags
//   port_gnt : one-hot {B,A} grant vector for a port index
package ram_arbiter2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  function automatic logic [1:0] port_gnt(input logic port);
    return (port == PORT_B) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter2.sv
// Two-port access controller for the byte-enabled 32-bit BRAM.
// Port A (CPU data) and port B (loader/debug) share one RAM port through a
// req/ack handshake. The winning request is latched, the RAM is driven for
// one cycle, then ack is pulsed together with registered read data.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_a_* / o_a_*           port A: req, wr, be, addr, wdata in; rdata, ack out
//   i_b_* / o_b_*           port B: same as port A
//   o_ram_*                 RAM en/wr/be/addr/wdata (registered, 0 outside ACCESS)
//   i_ram_rdata             RAM read data, valid at the end of the ACCESS cycle
//   o_gnt                   one-hot current owner {B,A}, 00 when idle
//
// state  | meaning
// IDLE   | waiting for a request; arbitrate and latch winner fields
// ACCESS | RAM enabled with latched fields; read data captured at exit
// ACK    | winner's ack high for one cycle; last owner updated
module ram_arbiter2
  import ram_arbiter2_pkg::*;
#(
  parameter int num_kbytes  = 128,
  parameter bit round_robin = 1'b1,
  localparam int AW = $clog2(num_kbytes * 1024)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_req,
  input  logic          i_a_wr,
  input  logic          i_a_be,
  input  logic [AW-1:0] i_a_addr,
  input  logic [31:0]   i_a_wdata,
  output logic [31:0]   o_a_rdata,
  output logic          o_a_ack,
  input  logic          i_b_req,
  input  logic          i_b_wr,
  input  logic          i_b_be,
  input  logic [AW-1:0] i_b_addr,
  input  logic [31:0]   i_b_wdata,
  output logic [31:0]   o_b_rdata,
  output logic          o_b_ack,
  output logic          o_ram_en,
  output logic          o_ram_wr,
  output logic          o_ram_be,
  output logic [AW-1:0] o_ram_addr,
  output logic [31:0]   o_ram_wdata,
  input  logic [31:0]   i_ram_rdata,
  output logic [1:0]    o_gnt
);

  state_t        r_state,     w_state_nxt;
  logic          r_winner,    w_winner_nxt;
  logic          r_last,      w_last_nxt;
  logic [1:0]    r_gnt,       w_gnt_nxt;
  logic          r_ram_en,    w_ram_en_nxt;
  logic          r_ram_wr,    w_ram_wr_nxt;
  logic          r_ram_be,    w_ram_be_nxt;
  logic [AW-1:0] r_ram_addr,  w_ram_addr_nxt;
  logic [31:0]   r_ram_wdata, w_ram_wdata_nxt;
  logic          r_a_ack,     w_a_ack_nxt;
  logic          r_b_ack,     w_b_ack_nxt;
  logic [31:0]   r_a_rdata,   w_a_rdata_nxt;
  logic [31:0]   r_b_rdata,   w_b_rdata_nxt;

  logic w_arb_valid;
  logic w_arb_win;

  rr_arb2 u_arb (
    .i_a_req       (i_a_req),
    .i_b_req       (i_b_req),
    .i_last        (r_last),
    .i_round_robin (round_robin),
    .o_valid       (w_arb_valid),
    .o_win         (w_arb_win)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_winner_nxt    = r_winner;
    w_last_nxt      = r_last;
    w_gnt_nxt       = r_gnt;
    w_ram_en_nxt    = 1'b0;
    w_ram_wr_nxt    = 1'b0;
    w_ram_be_nxt    = 1'b0;
    w_ram_addr_nxt  = '0;
    w_ram_wdata_nxt = '0;
    w_a_ack_nxt     = 1'b0;
    w_b_ack_nxt     = 1'b0;
    w_a_rdata_nxt   = r_a_rdata;
    w_b_rdata_nxt   = r_b_rdata;

    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = 2'b00;
        if (w_arb_valid) begin
          w_state_nxt  = ST_ACCESS;
          w_winner_nxt = w_arb_win;
          w_gnt_nxt    = port_gnt(w_arb_win);
          w_ram_en_nxt = 1'b1;
          if (w_arb_win == PORT_B) begin
            w_ram_wr_nxt    = i_b_wr;
            w_ram_be_nxt    = i_b_be;
            w_ram_addr_nxt  = i_b_addr;
            w_ram_wdata_nxt = i_b_wdata;
          end else begin
            w_ram_wr_nxt    = i_a_wr;
            w_ram_be_nxt    = i_a_be;
            w_ram_addr_nxt  = i_a_addr;
            w_ram_wdata_nxt = i_a_wdata;
          end
        end
      end
      ST_ACCESS: begin
        // RAM runs on the falling edge, so its read data is settled here.
        // Writes leave the requester's rdata untouched.
        w_state_nxt = ST_ACK;
        if (r_winner == PORT_B) begin
          w_b_ack_nxt = 1'b1;
          if (!r_ram_wr) w_b_rdata_nxt = i_ram_rdata;
        end else begin
          w_a_ack_nxt = 1'b1;
          if (!r_ram_wr) w_a_rdata_nxt = i_ram_rdata;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
        w_last_nxt  = r_winner;
        w_gnt_nxt   = 2'b00;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_winner    <= PORT_A;
      r_last      <= PORT_B;
      r_gnt       <= 2'b00;
      r_ram_en    <= 1'b0;
      r_ram_wr    <= 1'b0;
      r_ram_be    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_winner    <= w_winner_nxt;
      r_last      <= w_last_nxt;
      r_gnt       <= w_gnt_nxt;
      r_ram_en    <= w_ram_en_nxt;
      r_ram_wr    <= w_ram_wr_nxt;
      r_ram_be    <= w_ram_be_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_wdata <= w_ram_wdata_nxt;
      r_a_ack     <= w_a_ack_nxt;
      r_b_ack     <= w_b_ack_nxt;
      r_a_rdata   <= w_a_rdata_nxt;
      r_b_rdata   <= w_b_rdata_nxt;
    end
  end

  assign o_a_rdata   = r_a_rdata;
  assign o_a_ack     = r_a_ack;
  assign o_b_rdata   = r_b_rdata;
  assign o_b_ack     = r_b_ack;
  assign o_ram_en    = r_ram_en;
  assign o_ram_wr    = r_ram_wr;
  assign o_ram_be    = r_ram_be;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_gnt       = r_gnt;

endmodule

// Combinational two-way winner select.
//   i_a_req, i_b_req : pending requests
//   i_last           : port index of the previous owner
//   i_round_robin    : 1 = alternate on contention, 0 = port A fixed priority
//   o_valid          : at least one request pending
//   o_win            : winning port index (meaningful when o_valid)
module rr_arb2
  import ram_arbiter2_pkg::*;
(
  input  logic i_a_req,
  input  logic i_b_req,
  input  logic i_last,
  input  logic i_round_robin,
  output logic o_valid,
  output logic o_win
);

  assign o_valid = i_a_req | i_b_req;

  always_comb begin
    o_win = PORT_A;
    if (i_a_req && i_b_req) begin
      o_win = (i_round_robin && (i_last == PORT_A)) ? PORT_B : PORT_A;
    end else if (i_b_req) begin
      o_win = PORT_B;
    end
  end

endmodule

// File: tb/tb_ram_arbiter2.sv
module tb_ram_arbiter2;

  localparam int   AW  = $clog2(128 * 1024);
  localparam logic P_A = 1'b0;
  localparam logic P_B = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_wr, a_be, b_req, b_wr, b_be;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_wdata, b_wdata;
  logic [31:0]   a_rdata, b_rdata;
  logic          a_ack, b_ack;
  logic          ram_en, ram_wr, ram_be;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;
  logic [1:0]    gnt;

  // second instance with fixed priority; only req lines are exercised
  logic          a1_req, b1_req;
  logic          d1_bit = 1'b0;
  logic [AW-1:0] d1_addr = '0;
  logic [31:0]   d1_data = '0;
  logic [31:0]   a1_rdata, b1_rdata, r1_wdata;
  logic          a1_ack, b1_ack, r1_en, r1_wr, r1_be;
  logic [AW-1:0] r1_addr;
  logic [1:0]    gnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_arbiter2 #(.num_kbytes(128), .round_robin(1'b1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_a_req(a_req), .i_a_wr(a_wr), .i_a_be(a_be), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
    .o_a_rdata(a_rdata), .o_a_ack(a_ack),
    .i_b_req(b_req), .i_b_wr(b_wr), .i_b_be(b_be), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
    .o_b_rdata(b_rdata), .o_b_ack(b_ack),
    .o_ram_en(ram_en), .o_ram_wr(ram_wr), .o_ram_be(ram_be), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_gnt(gnt)
  );

  ram_arbiter2 #(.num_kbytes(128), .round_robin(1'b0)) dut_fixed (
    .i_clk(clk), .i_rst(rst),
    .i_a_req(a1_req), .i_a_wr(d1_bit), .i_a_be(d1_bit), .i_a_addr(d1_addr), .i_a_wdata(d1_data),
    .o_a_rdata(a1_rdata), .o_a_ack(a1_ack),
    .i_b_req(b1_req), .i_b_wr(d1_bit), .i_b_be(d1_bit), .i_b_addr(d1_addr), .i_b_wdata(d1_data),
    .o_b_rdata(b1_rdata), .o_b_ack(b1_ack),
    .o_ram_en(r1_en), .o_ram_wr(r1_wr), .o_ram_be(r1_be), .o_ram_addr(r1_addr),
    .o_ram_wdata(r1_wdata), .i_ram_rdata(d1_data), .o_gnt(gnt1)
  );

  // RAM behaviour: clocked on the falling edge, byte lane from addr[1:0]
  logic [31:0] mem [int];
  always @(negedge clk) begin
    int w;
    int lane;
    logic [31:0] tmp;
    if (ram_en) begin
      w    = int'(ram_addr[AW-1:2]);
      lane = int'(ram_addr[1:0]);
      tmp  = mem.exists(w) ? mem[w] : 32'h0;
      if (ram_wr) begin
        if (ram_be) tmp[8*lane +: 8] = ram_wdata[8*lane +: 8];
        else        tmp = ram_wdata;
        mem[w] = tmp;
      end else begin
        ram_rdata = tmp;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete access on an idle bus; entered and left at posedge+1.
  task automatic do_access(input string tag, input logic port, input logic wr, input logic be,
                           input logic [AW-1:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input bit chg);
    if (port == P_B) begin
      b_req = 1'b1; b_wr = wr; b_be = be; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = 1'b1; a_wr = wr; a_be = be; a_addr = addr; a_wdata = wdata;
    end
    @(posedge clk); #1;
    chk({tag, " ram_en"},    32'(ram_en), 32'd1);
    chk({tag, " gnt"},       32'(gnt), (port == P_B) ? 32'd2 : 32'd1);
    chk({tag, " ram_addr"},  32'(ram_addr), 32'(addr));
    chk({tag, " ram_wr"},    32'(ram_wr), 32'(wr));
    chk({tag, " ram_be"},    32'(ram_be), 32'(be));
    chk({tag, " ram_wdata"}, ram_wdata, wdata);
    if (chg) begin
      if (port == P_B) begin b_addr = addr + AW'(4); b_wdata = ~wdata; end
      else             begin a_addr = addr + AW'(4); a_wdata = ~wdata; end
    end
    @(posedge clk); #1;
    chk({tag, " ram_en off"}, 32'(ram_en), 32'd0);
    chk({tag, " ram_addr off"}, 32'(ram_addr), 32'd0);
    chk({tag, " ack"},       32'(port == P_B ? b_ack : a_ack), 32'd1);
    chk({tag, " other ack"}, 32'(port == P_B ? a_ack : b_ack), 32'd0);
    chk({tag, " rdata"},     (port == P_B) ? b_rdata : a_rdata, exp_rd);
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ack end"},   32'(port == P_B ? b_ack : a_ack), 32'd0);
    chk({tag, " gnt end"},   32'(gnt), 32'd0);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(0, 31));
  endfunction

  typedef struct {
    logic          port;
    logic          wr;
    logic          be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rd;
  } vec_t;

  vec_t vecs [9];

  // random-phase reference state
  logic [31:0]   ref_mem [8];
  int            cnt;
  logic          m_last, m_port, m_wr, m_be;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, exp_ra, exp_rb, tmp;
  logic [1:0]    m_gnt;
  logic          e_en, e_acka, e_ackb;
  bit            pend_a, pend_b;
  int            n_ack, na, nb;
  int            ack_port [4];
  int            ack_cyc [4];

  initial begin
    vecs[0] = '{P_A, 1'b0, 1'b0, 17'h100, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{P_B, 1'b1, 1'b0, 17'h200, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{P_B, 1'b1, 1'b1, 17'h203, 32'hAB000000, 32'h0};
    vecs[3] = '{P_A, 1'b0, 1'b0, 17'h200, 32'h0,        32'hABADBEEF};
    vecs[4] = '{P_B, 1'b1, 1'b1, 17'h200, 32'h00000011, 32'h0};
    vecs[5] = '{P_B, 1'b0, 1'b0, 17'h200, 32'h0,        32'hABADBE11};
    vecs[6] = '{P_A, 1'b1, 1'b0, 17'h104, 32'h12345678, 32'hABADBEEF};
    vecs[7] = '{P_B, 1'b0, 1'b0, 17'h104, 32'h0,        32'h12345678};
    vecs[8] = '{P_A, 1'b0, 1'b1, 17'h201, 32'h0,        32'hABADBE11};

    rst = 1'b1;
    a_req = 0; a_wr = 0; a_be = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_wr = 0; b_be = 0; b_addr = '0; b_wdata = '0;
    a1_req = 0; b1_req = 0;
    mem[32'h100 >> 2] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst ram_en",    32'(ram_en), 32'd0);
    chk("rst ram_wr",    32'(ram_wr), 32'd0);
    chk("rst ram_be",    32'(ram_be), 32'd0);
    chk("rst ram_addr",  32'(ram_addr), 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'd0);
    chk("rst gnt",       32'(gnt), 32'd0);
    chk("rst a_ack",     32'(a_ack), 32'd0);
    chk("rst b_ack",     32'(b_ack), 32'd0);
    chk("rst a_rdata",   a_rdata, 32'd0);
    chk("rst b_rdata",   b_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle ram_en", 32'(ram_en), 32'd0);

    for (int i = 0; i < 9; i++)
      do_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].wr, vecs[i].be,
                vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, 1'b0);

    // fields changed after the grant must not affect the access
    do_access("field change", P_A, 1'b0, 1'b0, 17'h100, 32'h0, 32'hDEADBEEF, 1'b1);

    // reset while the RAM is enabled
    a_req = 1'b1; a_wr = 1'b0; a_be = 1'b0; a_addr = 17'h104;
    @(posedge clk); #1;
    chk("rstacc ram_en before", 32'(ram_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstacc ram_en",   32'(ram_en), 32'd0);
    chk("rstacc gnt",      32'(gnt), 32'd0);
    chk("rstacc ram_addr", 32'(ram_addr), 32'd0);
    chk("rstacc a_ack",    32'(a_ack), 32'd0);
    chk("rstacc a_rdata",  a_rdata, 32'd0);
    a_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rstacc no ack", 32'(a_ack | b_ack), 32'd0);
    end
    do_access("post rst", P_A, 1'b0, 1'b0, 17'h104, 32'h0, 32'h12345678, 1'b0);

    // round-robin contention right after reset: A first, then alternate
    rst = 1'b1; #2; rst = 1'b0;
    a_req = 1'b1; a_wr = 1'b0; a_be = 1'b0; a_addr = 17'h100;
    b_req = 1'b1; b_wr = 1'b0; b_be = 1'b0; b_addr = 17'h104;
    n_ack = 0;
    for (int i = 0; i < 16 && n_ack < 4; i++) begin
      @(posedge clk); #1;
      if (a_ack) begin
        ack_port[n_ack] = 0; ack_cyc[n_ack] = i; n_ack++;
        chk("rr a_rdata", a_rdata, 32'hDEADBEEF);
        chk("rr single ack", 32'(b_ack), 32'd0);
      end else if (b_ack) begin
        ack_port[n_ack] = 1; ack_cyc[n_ack] = i; n_ack++;
        chk("rr b_rdata", b_rdata, 32'h12345678);
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("rr ack count", 32'(n_ack), 32'd4);
    for (int i = 0; i < n_ack; i++)
      chk($sformatf("rr order %0d", i), 32'(ack_port[i]), 32'(i % 2));
    for (int i = 1; i < n_ack; i++)
      chk($sformatf("rr spacing %0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    repeat (3) @(posedge clk);
    #1;

    // fixed priority: A takes every access while it holds req
    a1_req = 1'b1; b1_req = 1'b1; na = 0; nb = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      na += int'(a1_ack); nb += int'(b1_ack);
    end
    a1_req = 1'b0;
    chk("fixed a acks", 32'(na), 32'd5);
    chk("fixed b acks", 32'(nb), 32'd0);
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (b1_ack) begin nb++; b1_req = 1'b0; end
    end
    b1_req = 1'b0;
    chk("fixed b after a drops", 32'(nb), 32'd1);

    // randomized traffic against a transaction-level reference
    rst = 1'b1; #2; rst = 1'b0;
    mem.delete();
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    cnt = 0; m_last = P_B; m_gnt = 2'b00; exp_ra = '0; exp_rb = '0;
    m_port = P_A; m_wr = 0; m_be = 0; m_addr = '0; m_wdata = '0;
    pend_a = 0; pend_b = 0; a_req = 0; b_req = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend_a && $urandom_range(0, 2) == 0) begin
        pend_a = 1; a_req = 1'b1; a_wr = 1'($urandom_range(0, 1)); a_be = 1'($urandom_range(0, 1));
        a_addr = rnd_addr(); a_wdata = $urandom;
      end
      if (!pend_b && $urandom_range(0, 2) == 0) begin
        pend_b = 1; b_req = 1'b1; b_wr = 1'($urandom_range(0, 1)); b_be = 1'($urandom_range(0, 1));
        b_addr = rnd_addr(); b_wdata = $urandom;
      end
      @(posedge clk); #1;
      e_en = 0; e_acka = 0; e_ackb = 0;
      if (cnt == 0) begin
        if (a_req || b_req) begin
          if (a_req && b_req) m_port = ~m_last;
          else                m_port = b_req ? P_B : P_A;
          m_last  = m_port;
          m_wr    = (m_port == P_B) ? b_wr    : a_wr;
          m_be    = (m_port == P_B) ? b_be    : a_be;
          m_addr  = (m_port == P_B) ? b_addr  : a_addr;
          m_wdata = (m_port == P_B) ? b_wdata : a_wdata;
          m_gnt   = (m_port == P_B) ? 2'b10 : 2'b01;
          e_en = 1; cnt = 2;
        end
      end else begin
        if (cnt == 2) begin
          if (m_port == P_B) e_ackb = 1; else e_acka = 1;
          tmp = ref_mem[m_addr[4:2]];
          if (!m_wr) begin
            if (m_port == P_B) exp_rb = tmp; else exp_ra = tmp;
          end else begin
            if (m_be) tmp[8*int'(m_addr[1:0]) +: 8] = m_wdata[8*int'(m_addr[1:0]) +: 8];
            else      tmp = m_wdata;
            ref_mem[m_addr[4:2]] = tmp;
          end
        end
        if (cnt == 1) m_gnt = 2'b00;
        cnt--;
      end
      chk("rnd ram_en",    32'(ram_en), 32'(e_en));
      chk("rnd ram_wr",    32'(ram_wr), 32'(e_en & m_wr));
      chk("rnd ram_be",    32'(ram_be), 32'(e_en & m_be));
      chk("rnd ram_addr",  32'(ram_addr), e_en ? 32'(m_addr) : 32'd0);
      chk("rnd ram_wdata", ram_wdata, e_en ? m_wdata : 32'd0);
      chk("rnd gnt",       32'(gnt), 32'(m_gnt));
      chk("rnd a_ack",     32'(a_ack), 32'(e_acka));
      chk("rnd b_ack",     32'(b_ack), 32'(e_ackb));
      chk("rnd a_rdata",   a_rdata, exp_ra);
      chk("rnd b_rdata",   b_rdata, exp_rb);
      if (e_acka) begin pend_a = 0; a_req = 1'b0; end
      if (e_ackb) begin pend_b = 0; b_req = 1'b0; end
      if (e_en) begin
        // owner may scribble over its fields or drop req once granted
        if (m_port == P_B) begin
          b_addr = rnd_addr(); b_wdata = $urandom; b_wr = 1'($urandom_range(0, 1));
          b_req = 1'($urandom_range(0, 1));
        end else begin
          a_addr = rnd_addr(); a_wdata = $urandom; a_wr = 1'($urandom_range(0, 1));
          a_req = 1'($urandom_range(0, 1));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
